bit_split16: RTL and testbench

Sequential inverse of the 16-bit bitwise OR used in the datapath. It accepts one 16-bit vector, then emits it back as a stream of one-hot 16-bit words, lowest set bit first, one word per handshake. The OR of all emitted words equals the accepted vector. It sits between a mask producer (OR-merged request/flag vectors) and a per-bit consumer (e.g. a serial servicer), with valid/ready handshakes on both sides.

---
 rtl/bit_split_pkg.sv | 6 +
 rtl/lsb_find16.sv | 16 +
 rtl/bit_split16.sv | 46 ++++
 tb/tb_bit_split16.sv | 117 +++++++++++
 4 files changed

// File: rtl/bit_split_pkg.sv
// bit_split_pkg: shared constants and state encoding for bit_split16
package bit_split_pkg;
  localparam int N = 16;
  localparam int IW = 4;
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;
endpackage

// File: rtl/lsb_find16.sv
// lsb_find16: lowest set bit of a 16-bit vector as one-hot and index, plus at-most-one-bit flag
module lsb_find16
  import bit_split_pkg::*;
(
  input  logic [N-1:0]  v,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          single
);
  assign onehot = v & (~v + N'(1));
  assign single = (v & (v - N'(1))) == '0;
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = idx | (onehot[i] ? IW'(i) : IW'(0));
  end
endmodule

// File: rtl/bit_split16.sv
// bit_split16: splits an accepted 16-bit vector into a stream of one-hot beats, lowest bit first
module bit_split16
  import bit_split_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_onehot,
  output logic [IW-1:0] out_idx,
  output logic          out_last
);
  state_t state;
  logic [N-1:0] mask, oh;
  logic [IW-1:0] idx;
  logic single, zflag, emit;
  lsb_find16 u_find (.v(mask), .onehot(oh), .idx(idx), .single(single));
  assign emit = state == EMIT;
  assign in_ready = !emit;
  assign out_valid = emit;
  assign out_onehot = emit && !zflag ? oh : '0;
  assign out_idx = emit ? idx : '0;
  assign out_last = emit && single;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mask <= '0;
      zflag <= 1'b0;
    end else if (!emit) begin
      if (in_valid) begin
        mask <= in_data;
        zflag <= in_data == '0;
        state <= EMIT;
      end
    end else if (out_ready) begin
      mask <= mask & ~out_onehot;
      if (single) begin
        state <= IDLE;
        zflag <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bit_split16.sv
// tb_bit_split16: directed and randomized checks of bit_split16 against a bit-list reference model
module tb_bit_split16;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid, out_last;
  logic [15:0] out_onehot;
  logic [3:0] out_idx;
  int n_cmp = 0, n_err = 0;
  bit_split16 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot), .out_idx(out_idx),
    .out_last(out_last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_beat(input int q[$], input int k);
    logic [15:0] one = 16'd1;
    int beats = q.size() == 0 ? 1 : q.size();
    chk("out_valid", out_valid, 1);
    chk("in_ready_busy", in_ready, 0);
    chk("onehot", out_onehot, q.size() == 0 ? 16'h0 : one << q[k]);
    chk("idx", out_idx, q.size() == 0 ? 0 : q[k]);
    chk("last", out_last, k == beats - 1);
  endtask
  task automatic run_vec(input logic [15:0] v, input int stall, input bit rnd);
    int q[$];
    int k = 0, cyc = 0, beats;
    logic [15:0] acc = '0;
    for (int i = 0; i < 16; i++) if (v[i]) q.push_back(i);
    beats = q.size() == 0 ? 1 : q.size();
    chk("idle_ready", in_ready, 1);
    chk("idle_valid", out_valid, 0);
    in_valid = 1; in_data = v;
    @(posedge clk); #1;
    in_valid = 0; in_data = 16'($urandom);
    while (k < beats && cyc < 200) begin
      if (cyc < stall) begin
        out_ready = 0; in_valid = 1; in_data = 16'hFFFF;
      end else begin
        in_valid = 0; out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      chk_beat(q, k);
      if (out_ready) begin
        acc = acc | out_onehot;
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (k < beats) chk("timeout_beats", k, beats);
    chk("or_of_beats", acc, v);
    chk("ready_after", in_ready, 1);
    chk("valid_after", out_valid, 0);
    out_ready = 0;
  endtask
  initial begin
    int q[$];
    logic [15:0] v;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_onehot", out_onehot, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_onehot", out_onehot, 0);
    run_vec(16'h8421, 0, 0);
    run_vec(16'h0000, 0, 0);
    run_vec(16'h0006, 3, 0);
    run_vec(16'hFFFF, 0, 0);
    run_vec(16'h8000, 0, 0);
    run_vec(16'h0001, 2, 0);
    for (int i = 0; i < 16; i++) q.push_back(4 + i % 4);
    q = {4, 5, 6, 7};
    out_ready = 1; in_valid = 1; in_data = 16'h00F0;
    @(posedge clk); #1;
    in_valid = 0;
    for (int k = 0; k < 2; k++) begin
      chk_beat(q, k);
      @(posedge clk); #1;
    end
    rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_onehot", out_onehot, 0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_ready", in_ready, 1);
    end
    out_ready = 0;
    for (int t = 0; t < 40; t++) begin
      case (t % 5)
        0: v = 16'h0;
        1: v = 16'h1 << $urandom_range(0, 15);
        default: v = 16'($urandom);
      endcase
      run_vec(v, $urandom_range(0, 2), 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
